sr_flag_arbiter: RTL and testbench

Shares one bank of NUM_FLAGS SR flip-flop flags between NUM_REQ requesters.
- Each requester posts a set/reset command for one flag index.
- A round-robin arbiter grants one command per clock.
- The granted command is applied SR-style: S sets, R resets, neither holds.
- Sits between control agents and the status-flag bank; q/qn outputs drive downstream logic directly.

---
 rtl/sr_flag_pkg.sv | 26 ++
 rtl/sr_flag_arbiter_rr_arbiter.sv | 35 +++
 rtl/sr_flag_arbiter.sv | 122 ++++++++++++
 tb/tb_sr_flag_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
// Shared types and defaults for the SR flag arbiter.
// SR_TOGGLE_EN (in sr_flag_arbiter) turns S=R=1 into a toggle.
package sr_flag_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_FLAGS = 8;

    typedef enum logic [1:0] {
        CMD_HOLD,
        CMD_SET,
        CMD_RST,
        CMD_BOTH
    } sr_cmd_e;

    function automatic sr_cmd_e sr_decode(input logic s, input logic r);
        sr_cmd_e cmd;
        unique case ({s, r})
            2'b10:   cmd = CMD_SET;
            2'b01:   cmd = CMD_RST;
            2'b11:   cmd = CMD_BOTH;
            default: cmd = CMD_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first unmasked request
// found searching upward from i_ptr, wrapping at NUM_REQ.
module rr_arbiter
    import sr_flag_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_valid
);

    logic [NUM_REQ-1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    // Offset k outer so the nearest candidate to the pointer wins.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_valid && w_elig[i] &&
                    i_ptr == PTR_W'((i + NUM_REQ - k) % NUM_REQ)) begin
                    o_gnt[i] = 1'b1;
                    o_valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin shared SR flag bank with sticky error flag.
// Define SR_TOGGLE_EN to make S=R=1 toggle the flag (JK style).
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_FLAGS = DEF_NUM_FLAGS,
    localparam int IDX_W    = $clog2(NUM_FLAGS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ-1:0]       i_req_s,
    input  logic [NUM_REQ-1:0]       i_req_r,
    input  logic [NUM_REQ*IDX_W-1:0] i_req_idx,
    input  logic                     i_err_clr,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_FLAGS-1:0]     o_q,
    output logic [NUM_FLAGS-1:0]     o_qn,
    output logic                     o_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_FLAGS-1:0] r_q;
    logic                 r_err;

    logic [NUM_REQ-1:0]   w_win;
    logic                 w_valid;
    logic [PTR_W-1:0]     w_win_id;
    logic                 w_s;
    logic                 w_r;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_in_rng;
    sr_cmd_e              w_cmd;
    logic [NUM_FLAGS-1:0] w_q_nxt;
    logic                 w_err_set;
    logic [PTR_W-1:0]     w_ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (i_req),
        .i_mask  (r_gnt),
        .i_ptr   (r_ptr),
        .o_gnt   (w_win),
        .o_valid (w_valid)
    );

    always_comb begin
        w_win_id = '0;
        w_s      = 1'b0;
        w_r      = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_win_id = PTR_W'(i);
                w_s      = i_req_s[i];
                w_r      = i_req_r[i];
                w_idx    = i_req_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    assign w_cmd    = sr_decode(w_s, w_r);
    assign w_in_rng = int'(w_idx) < NUM_FLAGS;

    assign w_ptr_nxt = (w_win_id == PTR_W'(NUM_REQ - 1)) ?
                       '0 : w_win_id + 1'b1;

    always_comb begin
        w_q_nxt   = r_q;
        w_err_set = 1'b0;
        if (w_valid) begin
            if (!w_in_rng) begin
                w_err_set = 1'b1;
            end else begin
                case (w_cmd)
                    CMD_SET:  w_q_nxt[w_idx] = 1'b1;
                    CMD_RST:  w_q_nxt[w_idx] = 1'b0;
                    CMD_BOTH: begin
`ifdef SR_TOGGLE_EN
                        w_q_nxt[w_idx] = ~r_q[w_idx];
`else
                        w_err_set = 1'b1;
`endif
                    end
                    default:  w_q_nxt = r_q;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_q   <= '0;
            r_err <= 1'b0;
        end else begin
            r_gnt <= w_win;
            r_q   <= w_q_nxt;
            if (w_valid) begin
                r_ptr <= w_ptr_nxt;
            end
            // A fresh error outranks a simultaneous clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_gnt = r_gnt;
    assign o_q   = r_q;
    assign o_qn  = ~r_q;
    assign o_err = r_err;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter (4 requesters, 8 flags).
// Directed scenarios plus random traffic against a behavioural model.
module tb_sr_flag_arbiter;

    localparam int NR = 4;
    localparam int NF = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] req_s;
    logic [NR-1:0] req_r;
    logic [NR*IW-1:0] req_idx;
    logic          err_clr;
    logic [NR-1:0] gnt;
    logic [NF-1:0] q;
    logic [NF-1:0] qn;
    logic          err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [NF-1:0] m_q;
    logic [NR-1:0] m_gnt;
    logic          m_err;
    int            m_ptr;

    always #5 clk = ~clk;

    sr_flag_arbiter #(
        .NUM_REQ   (NR),
        .NUM_FLAGS (NF)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_req_s   (req_s),
        .i_req_r   (req_r),
        .i_req_idx (req_idx),
        .i_err_clr (err_clr),
        .o_gnt     (gnt),
        .o_q       (q),
        .o_qn      (qn),
        .o_err     (err)
    );

    task automatic model_reset();
        m_q   = '0;
        m_gnt = '0;
        m_err = 1'b0;
        m_ptr = 0;
    endtask

    // Predict the edge from current inputs, then advance one clock.
    task automatic tick();
        logic [NR-1:0] elig;
        int w;
        int k;
        logic nerr;
        elig = req & ~m_gnt;
        w = -1;
        for (int n = 0; n < NR; n++) begin
            int j;
            j = (m_ptr + n) % NR;
            if (w < 0 && elig[j]) w = j;
        end
        m_gnt = '0;
        nerr = 1'b0;
        if (w >= 0) begin
            m_gnt[w] = 1'b1;
            m_ptr = (w + 1) % NR;
            k = int'(req_idx[w*IW +: IW]);
            if (k >= NF) nerr = 1'b1;
            else if (req_s[w] && !req_r[w]) m_q[k] = 1'b1;
            else if (!req_s[w] && req_r[w]) m_q[k] = 1'b0;
            else if (req_s[w] && req_r[w]) begin
`ifdef SR_TOGGLE_EN
                m_q[k] = ~m_q[k];
`else
                nerr = 1'b1;
`endif
            end
        end
        if (nerr) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        req_s = '0;
        req_r = '0;
        req_idx = '0;
        err_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (q !== 8'h00) begin
            n_err++;
            $display("FAIL reset_q got=%h exp=00", q);
        end
        n_chk++;
        if (qn !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_qn got=%h exp=FF", qn);
        end
        n_chk++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt got=%b exp=0000", gnt);
        end
        n_chk++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err got=%b exp=0", err);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req = 4'b0001;
        req_s[0] = 1'b1;
        req_idx[2:0] = 3'd1;
        tick();
        n_chk++;
        if (gnt !== 4'b0001 || q !== 8'h02) begin
            n_err++;
            $display("FAIL midrst_pre got=%b/%h exp=0001/02", gnt, q);
        end
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_gnt got=%b exp=0000", gnt);
        end
        n_chk++;
        if (q !== 8'h00 || qn !== 8'hFF) begin
            n_err++;
            $display("FAIL midrst_q got=%h/%h exp=00/FF", q, qn);
        end
        req = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_set();
        apply_reset();
        req = 4'b0001;
        req_s[0] = 1'b1;
        req_r[0] = 1'b0;
        req_idx[2:0] = 3'd3;
        tick();
        n_chk++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL set_gnt got=%b exp=0001", gnt);
        end
        n_chk++;
        if (q !== 8'h08 || qn !== 8'hF7) begin
            n_err++;
            $display("FAIL set_q got=%h/%h exp=08/F7", q, qn);
        end
        req_s[0] = 1'b0;
        req_r[0] = 1'b1;
        tick();
        n_chk++;
        if (gnt !== 4'b0000 || q !== 8'h08) begin
            n_err++;
            $display("FAIL mask_cycle got=%b/%h exp=0000/08", gnt, q);
        end
        tick();
        n_chk++;
        if (gnt !== 4'b0001 || q !== 8'h00) begin
            n_err++;
            $display("FAIL rst_q got=%b/%h exp=0001/00", gnt, q);
        end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (gnt !== seq[c] || gnt !== m_gnt) begin
                n_err++;
                $display("FAIL rr_%0d got=%b exp=%b", c, gnt, seq[c]);
            end
        end
        n_chk++;
        if (q !== 8'h00 || err !== 1'b0) begin
            n_err++;
            $display("FAIL rr_hold got=%h/%b exp=00/0", q, err);
        end
        req = '0;
        tick();
    endtask

    task automatic test_conflict();
        apply_reset();
        req = 4'b0110;
        req_s[1] = 1'b1;
        req_idx[5:3] = 3'd5;
        req_r[2] = 1'b1;
        req_idx[8:6] = 3'd5;
        tick();
        n_chk++;
        if (gnt !== 4'b0010 || q !== 8'h20) begin
            n_err++;
            $display("FAIL conf_1 got=%b/%h exp=0010/20", gnt, q);
        end
        req[1] = 1'b0;
        tick();
        n_chk++;
        if (gnt !== 4'b0100 || q !== 8'h00) begin
            n_err++;
            $display("FAIL conf_2 got=%b/%h exp=0100/00", gnt, q);
        end
        req = '0;
        req_s = '0;
        req_r = '0;
        tick();
    endtask

    task automatic test_illegal();
        logic [NF-1:0] e_q1;
        logic [NF-1:0] e_q2;
        logic          e_e;
`ifdef SR_TOGGLE_EN
        e_q1 = 8'h00;
        e_q2 = 8'h04;
        e_e  = 1'b0;
`else
        e_q1 = 8'h04;
        e_q2 = 8'h04;
        e_e  = 1'b1;
`endif
        apply_reset();
        req = 4'b0001;
        req_s[0] = 1'b1;
        req_idx[2:0] = 3'd2;
        tick();
        req = 4'b0010;
        req_s[1] = 1'b1;
        req_r[1] = 1'b1;
        req_idx[5:3] = 3'd2;
        tick();
        n_chk++;
        if (gnt !== 4'b0010 || q !== e_q1 || err !== e_e) begin
            n_err++;
            $display("FAIL both_1 got=%b/%h/%b exp=0010/%h/%b",
                     gnt, q, err, e_q1, e_e);
        end
        req = 4'b0100;
        req_s[2] = 1'b1;
        req_r[2] = 1'b1;
        req_idx[8:6] = 3'd2;
        err_clr = 1'b1;
        tick();
        n_chk++;
        if (gnt !== 4'b0100 || q !== e_q2 || err !== e_e) begin
            n_err++;
            $display("FAIL both_clr got=%b/%h/%b exp=0100/%h/%b",
                     gnt, q, err, e_q2, e_e);
        end
        req = '0;
        tick();
        n_chk++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr got=%b exp=0", err);
        end
        err_clr = 1'b0;
        req_s = '0;
        req_r = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_gnt[i] || !req[i]) begin
                    req[i]   = ($urandom_range(0, 2) != 0);
                    req_s[i] = 1'($urandom_range(0, 1));
                    req_r[i] = 1'($urandom_range(0, 1));
                    req_idx[i*IW +: IW] = 3'($urandom_range(0, 7));
                end
            end
            err_clr = ($urandom_range(0, 5) == 0);
            tick();
            n_chk++;
            if (gnt !== m_gnt) begin
                n_err++;
                $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, m_gnt);
            end
            n_chk++;
            if (q !== m_q || qn !== ~m_q) begin
                n_err++;
                $display("FAIL rnd_q c=%0d got=%h/%h exp=%h", c, q, qn, m_q);
            end
            n_chk++;
            if (err !== m_err) begin
                n_err++;
                $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err);
            end
        end
        req = '0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_s = '0;
        req_r = '0;
        req_idx = '0;
        err_clr = 1'b0;
        test_reset();
        test_reset_mid_grant();
        test_single_set();
        test_round_robin();
        test_conflict();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
